axis_tg_synth: RTL and testbench
================================

// Module: axis_tg_synth
// PURPOSE
//  Synthesizable AXI-Stream traffic generator: the transmit end paired with axis_checker on each mesh/torus endpoint.
//  Injects single-flit packets at a programmable Bernoulli load to LFSR-random destinations.
//  Each flit carries a timestamp and a per-destination sequence number, so the checker measures latency and ordering.
//  Sits between the on-chip test controller and the NoC axis_in port in hardware harnesses.
// PARAMETERS
//  SEED         1   16-bit LFSR seed, nonzero; 0 is replaced by 1
//  COUNT_WIDTH  32  width of all packet counters and num_packets
//  TID          0   constant tid of this source
//  TDATA_WIDTH  64  flit width, even, >= 2*COUNT_WIDTH is not required
//  TDEST_WIDTH  4   = $clog2(NUM_ROUTERS)
//  TID_WIDTH    4   tid width
//  NUM_ROUTERS  16  number of destinations, 2..2**TDEST_WIDTH
// PORTS
//  clk                 in   1              single clock
//  rst_n               in   1              asynchronous, active-low reset
//  load                in   16             injection probability = load/65536 per cycle
//  num_packets         in   COUNT_WIDTH    packets to generate per run; sampled on IDLE->RUN
//  start               in   1              level; begins a run
//  ticks               in   TDATA_WIDTH/2  free-running timestamp
//  done                out  1              run complete, all flits accepted
//  sent_packets        out  COUNT_WIDTH x [NUM_ROUTERS]  accepted packets per destination
//  total_sent_packets  out  COUNT_WIDTH    accepted packets, all destinations
//  axis_out_tvalid/tready/tdata/tlast/tid/tdest  out/in/out/out/out/out  1/1/TDATA_WIDTH/1/TID_WIDTH/TDEST_WIDTH  AXIS master
// BEHAVIOUR
//  Reset: state=IDLE; done=0; tvalid=0; tdata/tdest=0; tlast=1; tid=TID; all counters=0;
//   pending=0; generated=0; load LFSR=SEED; dest LFSR=SEED^16'hACE1 (0 -> 1).
//  LFSRs: 16-bit Galois, taps x^16+x^14+x^13+x^11+1; never reach 0.
//  FSM:
//   IDLE : start=1 -> latch num_packets into target; target==0 -> DONE, else RUN.
//   RUN  : each cycle advance load LFSR r; if r<load and generated<target: generated++, pending++.
//          generated==target -> DRAIN. start deassert ignored (run is sticky).
//   DRAIN: no generation; pending==0 and tvalid==0 -> DONE.
//   DONE : done=1 (registered, asserted the cycle state enters DONE); start=0 -> IDLE, done=0.
//  Output stage (one register, no skid):
//   tvalid=0 and pending>0: load flit next edge, pending--, advance dest LFSR.
//   tvalid=1: tdata/tdest/tid/tlast held stable until tready=1.
//   tvalid&tready and pending>0: back-to-back load, tvalid stays 1 (1 flit/cycle max).
//   tvalid&tready and pending==0: tvalid=0 next edge.
//   generate and load in same cycle: pending unchanged; pending saturates at all-ones.
//  Flit format: tlast=1; tid=TID; tdest=d where v=dest_lfsr[TDEST_WIDTH-1:0], d=(v>=NUM_ROUTERS)?v-NUM_ROUTERS:v;
//   tdata[TDATA_WIDTH-1:TDATA_WIDTH/2]=ticks at load edge;
//   tdata[TDATA_WIDTH/2-1:0]=sent_packets[d] (zero-extended/truncated) at load = per-destination sequence number.
//  Counters: on tvalid&tready: sent_packets[tdest]++, total_sent_packets++; wrap modulo 2**COUNT_WIDTH.
//   Counters cleared only by reset (persist across runs).
//  Sequence number sampled at load: only one flit in flight per source, so it equals count at acceptance.
//  Latency: generation edge -> tvalid >= 1 cycle (pending->register).
//  Reset mid-run: asynchronous clear of everything, tvalid drops immediately, in-flight flit discarded.
// TESTING
//  load=16'hFFFF, num_packets=100, tready=1 -> 100 flits, nearly back-to-back; done=1; total_sent_packets=100.
//  load=0, start=1 -> state stays RUN, tvalid never 1, done stays 0; rst_n low -> IDLE, all outputs at reset values.
//  num_packets=0, start=1 -> done=1 after 1 cycle, tvalid never asserted.
//  tready=0 for 50 cycles at load=0x8000 -> tvalid/tdata/tdest stable throughout; pending grows; flits drain on tready=1.
//  NUM_ROUTERS=12, 4096 packets -> every tdest<12; sum(sent_packets)=total_sent_packets; per-dest seq 0,1,2...
//  Loopback to axis_checker (TDEST=tdest), 1000 packets at load 0.3 -> checker error=0, recv counts match sent_packets.

Source files
------------

// File: rtl/axis_tg_synth.sv
// AXI-Stream traffic generator: Bernoulli-load single-flit packets to LFSR-random
// destinations, each flit stamped with a timestamp and a per-destination sequence number.
module axis_tg_synth #(
    parameter logic [15:0] SEED        = 16'd1,
    parameter int unsigned COUNT_WIDTH = 32,
    parameter int unsigned TID         = 0,
    parameter int unsigned TDATA_WIDTH = 64,
    parameter int unsigned TDEST_WIDTH = 4,
    parameter int unsigned TID_WIDTH   = 4,
    parameter int unsigned NUM_ROUTERS = 16
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic [15:0]                             load,
    input  logic [COUNT_WIDTH-1:0]                  num_packets,
    input  logic                                    start,
    input  logic [TDATA_WIDTH/2-1:0]                ticks,
    output logic                                    done,
    output logic [NUM_ROUTERS-1:0][COUNT_WIDTH-1:0] sent_packets,
    output logic [COUNT_WIDTH-1:0]                  total_sent_packets,
    output logic                                    axis_out_tvalid,
    input  logic                                    axis_out_tready,
    output logic [TDATA_WIDTH-1:0]                  axis_out_tdata,
    output logic                                    axis_out_tlast,
    output logic [TID_WIDTH-1:0]                    axis_out_tid,
    output logic [TDEST_WIDTH-1:0]                  axis_out_tdest
);

    localparam int unsigned HALF = TDATA_WIDTH / 2;
    localparam logic [15:0] SEED_LOAD = (SEED == 16'd0) ? 16'd1 : SEED;
    localparam logic [15:0] SEED_MIX  = SEED_LOAD ^ 16'hACE1;
    localparam logic [15:0] SEED_DEST = (SEED_MIX == 16'd0) ? 16'd1 : SEED_MIX;

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    // Galois LFSR x^16+x^14+x^13+x^11+1; a nonzero state never reaches zero.
    function automatic logic [15:0] lfsr_step(input logic [15:0] x);
        lfsr_step = {1'b0, x[15:1]} ^ (x[0] ? 16'hB400 : 16'h0000);
    endfunction

    state_e                                 state_q, state_d;
    logic [COUNT_WIDTH-1:0]                 target_q, target_d;
    logic [COUNT_WIDTH-1:0]                 gen_q, gen_d;
    logic [COUNT_WIDTH-1:0]                 pend_q, pend_d;
    logic [15:0]                            lfsr_load_q, lfsr_load_d;
    logic [15:0]                            lfsr_dest_q, lfsr_dest_d;
    logic                                   done_q, done_d;
    logic                                   valid_q, valid_d;
    logic [TDATA_WIDTH-1:0]                 data_q, data_d;
    logic [TDEST_WIDTH-1:0]                 dest_q, dest_d;
    logic [NUM_ROUTERS-1:0][COUNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [COUNT_WIDTH-1:0]                 total_q, total_d;

    logic                   accept;
    logic                   load_flit;
    logic                   gen_fire;
    logic [TDEST_WIDTH:0]   dest_raw;
    logic [TDEST_WIDTH:0]   dest_fold;
    logic [TDEST_WIDTH-1:0] dest_sel;
    logic [COUNT_WIDTH-1:0] seq;

    assign accept    = valid_q & axis_out_tready;
    // The register refills whenever it is empty or being emptied this cycle.
    assign load_flit = (pend_q != '0) && (!valid_q || axis_out_tready);

    assign dest_raw  = {1'b0, lfsr_dest_q[TDEST_WIDTH-1:0]};
    assign dest_fold = (dest_raw >= (TDEST_WIDTH + 1)'(NUM_ROUTERS))
                     ? dest_raw - (TDEST_WIDTH + 1)'(NUM_ROUTERS) : dest_raw;
    assign dest_sel  = dest_fold[TDEST_WIDTH-1:0];

    // Per-destination counters; the sequence number reads the post-acceptance count so a
    // back-to-back flit to the same destination gets the next number.
    always_comb begin
        cnt_d   = cnt_q;
        total_d = total_q;
        seq     = '0;
        for (int i = 0; i < NUM_ROUTERS; i++) begin
            if (accept && (dest_q == TDEST_WIDTH'(i))) begin
                cnt_d[i] = cnt_q[i] + COUNT_WIDTH'(1);
            end
        end
        if (accept) begin
            total_d = total_q + COUNT_WIDTH'(1);
        end
        for (int i = 0; i < NUM_ROUTERS; i++) begin
            if (dest_sel == TDEST_WIDTH'(i)) begin
                seq = cnt_d[i];
            end
        end
    end

    // Run-control FSM: generation decisions and the registered done flag.
    always_comb begin
        state_d     = state_q;
        target_d    = target_q;
        gen_d       = gen_q;
        lfsr_load_d = lfsr_load_q;
        gen_fire    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    target_d = num_packets;
                    gen_d    = '0;
                    state_d  = (num_packets == '0) ? StDone : StRun;
                end
            end
            StRun: begin
                lfsr_load_d = lfsr_step(lfsr_load_q);
                if ((lfsr_load_q < load) && (gen_q < target_q)) begin
                    gen_fire = 1'b1;
                    gen_d    = gen_q + COUNT_WIDTH'(1);
                end
                if (gen_d == target_q) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if ((pend_q == '0) && !valid_q) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (!start) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        done_d = (state_d == StDone);
    end

    // Output register and pending-flit bookkeeping.
    always_comb begin
        valid_d     = valid_q;
        data_d      = data_q;
        dest_d      = dest_q;
        lfsr_dest_d = lfsr_dest_q;
        pend_d      = pend_q;
        if (load_flit) begin
            valid_d     = 1'b1;
            dest_d      = dest_sel;
            data_d      = {ticks, HALF'(seq)};
            lfsr_dest_d = lfsr_step(lfsr_dest_q);
        end else if (accept) begin
            valid_d = 1'b0;
        end
        if (gen_fire && !load_flit) begin
            pend_d = (&pend_q) ? pend_q : pend_q + COUNT_WIDTH'(1);
        end else if (!gen_fire && load_flit) begin
            pend_d = pend_q - COUNT_WIDTH'(1);
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            target_q    <= '0;
            gen_q       <= '0;
            pend_q      <= '0;
            lfsr_load_q <= SEED_LOAD;
            lfsr_dest_q <= SEED_DEST;
            done_q      <= 1'b0;
            valid_q     <= 1'b0;
            data_q      <= '0;
            dest_q      <= '0;
            cnt_q       <= '0;
            total_q     <= '0;
        end else begin
            state_q     <= state_d;
            target_q    <= target_d;
            gen_q       <= gen_d;
            pend_q      <= pend_d;
            lfsr_load_q <= lfsr_load_d;
            lfsr_dest_q <= lfsr_dest_d;
            done_q      <= done_d;
            valid_q     <= valid_d;
            data_q      <= data_d;
            dest_q      <= dest_d;
            cnt_q       <= cnt_d;
            total_q     <= total_d;
        end
    end

    assign done               = done_q;
    assign sent_packets       = cnt_q;
    assign total_sent_packets = total_q;
    assign axis_out_tvalid    = valid_q;
    assign axis_out_tdata     = data_q;
    assign axis_out_tdest     = dest_q;
    assign axis_out_tlast     = 1'b1;
    assign axis_out_tid       = TID_WIDTH'(TID);

endmodule

// File: tb/tb_axis_tg_synth.sv
// Randomized bench for axis_tg_synth with a cycle-level behavioural model.
module tb_axis_tg_synth;

    localparam int CW  = 16;
    localparam int TDW = 64;
    localparam int DW  = 4;
    localparam int IW  = 4;
    localparam int NR  = 12;
    localparam int TIDV = 5;

    logic                   clk;
    logic                   rst_n;
    logic [15:0]            load;
    logic [CW-1:0]          num_packets;
    logic                   start;
    logic [TDW/2-1:0]       ticks;
    logic                   done;
    logic [NR-1:0][CW-1:0]  sent_packets;
    logic [CW-1:0]          total_sent_packets;
    logic                   tvalid;
    logic                   tready;
    logic [TDW-1:0]         tdata;
    logic                   tlast;
    logic [IW-1:0]          tid;
    logic [DW-1:0]          tdest;

    axis_tg_synth #(
        .SEED        (16'd1),
        .COUNT_WIDTH (CW),
        .TID         (TIDV),
        .TDATA_WIDTH (TDW),
        .TDEST_WIDTH (DW),
        .TID_WIDTH   (IW),
        .NUM_ROUTERS (NR)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .load               (load),
        .num_packets        (num_packets),
        .start              (start),
        .ticks              (ticks),
        .done               (done),
        .sent_packets       (sent_packets),
        .total_sent_packets (total_sent_packets),
        .axis_out_tvalid    (tvalid),
        .axis_out_tready    (tready),
        .axis_out_tdata     (tdata),
        .axis_out_tlast     (tlast),
        .axis_out_tid       (tid),
        .axis_out_tdest     (tdest)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;
    int rmode = 0;

    // Behavioural model: phase 0 idle, 1 running, 2 draining, 3 finished.
    int          m_phase;
    int          m_target;
    int          m_gen;
    int          m_pend;
    logic [15:0] m_lfsr_l;
    logic [15:0] m_lfsr_d;
    bit          m_done;
    bit          m_valid;
    logic [63:0] m_data;
    logic [3:0]  m_dest;
    logic [CW-1:0] m_cnt [NR];
    logic [CW-1:0] m_total;

    int acc_dest [$];
    int acc_seq [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] x);
        return x[0] ? ((x >> 1) ^ 16'hB400) : (x >> 1);
    endfunction

    task automatic model_reset();
        m_phase  = 0;
        m_target = 0;
        m_gen    = 0;
        m_pend   = 0;
        m_lfsr_l = 16'd1;
        m_lfsr_d = 16'd1 ^ 16'hACE1;
        m_done   = 0;
        m_valid  = 0;
        m_data   = '0;
        m_dest   = '0;
        m_total  = '0;
        for (int i = 0; i < NR; i++) m_cnt[i] = '0;
    endtask

    // One clock of the model, using the inputs as they stood before the edge.
    task automatic model_step();
        bit acc, ldf, fire;
        int v, d;
        if (!rst_n) begin
            model_reset();
            return;
        end
        acc  = m_valid && tready;
        ldf  = (m_pend > 0) && (!m_valid || tready);
        fire = 0;
        case (m_phase)
            0: if (start) begin
                m_target = int'(num_packets);
                m_gen    = 0;
                m_phase  = (m_target == 0) ? 3 : 1;
            end
            1: begin
                if (m_lfsr_l < load && m_gen < m_target) begin
                    fire = 1;
                    m_gen++;
                end
                m_lfsr_l = lfsr_next(m_lfsr_l);
                if (m_gen == m_target) m_phase = 2;
            end
            2: if (m_pend == 0 && !m_valid) m_phase = 3;
            default: if (!start) m_phase = 0;
        endcase
        m_done = (m_phase == 3);
        if (acc) begin
            m_cnt[m_dest] = m_cnt[m_dest] + 1'b1;
            m_total       = m_total + 1'b1;
        end
        if (ldf) begin
            v = int'(m_lfsr_d[3:0]);
            d = (v >= NR) ? v - NR : v;
            m_dest   = 4'(d);
            m_data   = {ticks, 32'(m_cnt[d])};
            m_valid  = 1;
            m_lfsr_d = lfsr_next(m_lfsr_d);
        end else if (acc) begin
            m_valid = 0;
        end
        m_pend = m_pend + int'(fire) - int'(ldf);
    endtask

    // Compare DUT against the model on every falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("done", 64'(done), 64'(m_done));
            check("tvalid", 64'(tvalid), 64'(m_valid));
            check("tlast", 64'(tlast), 64'd1);
            check("tid", 64'(tid), 64'(TIDV));
            check("total", 64'(total_sent_packets), 64'(m_total));
            for (int i = 0; i < NR; i++) begin
                check($sformatf("sent[%0d]", i), 64'(sent_packets[i]), 64'(m_cnt[i]));
            end
            if (m_valid) begin
                check("tdata", tdata, m_data);
                check("tdest", 64'(tdest), 64'(m_dest));
            end
            if (tvalid && tready) begin
                acc_dest.push_back(int'(tdest));
                acc_seq.push_back(int'(tdata[31:0]));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        ticks = $urandom;
        if (rmode == 1) tready = ($urandom_range(0, 9) < 7);
    endtask

    task automatic wait_done(input string name, input int budget);
        for (int i = 0; i < budget && !done; i++) cyc();
        check(name, 64'(done), 64'd1);
    endtask

    task automatic end_run();
        start = 1'b0;
        cyc();
        cyc();
    endtask

    int sum;

    initial begin
        rst_n = 1'b0;
        load = '0;
        num_packets = '0;
        start = 1'b0;
        ticks = '0;
        tready = 1'b0;
        model_reset();
        chk_en = 1'b1;
        cyc();
        cyc();
        check("rst_done", 64'(done), 64'd0);
        check("rst_tvalid", 64'(tvalid), 64'd0);
        check("rst_tdata", tdata, 64'd0);
        check("rst_total", 64'(total_sent_packets), 64'd0);
        rst_n = 1'b1;

        // Full load, always ready: 20 flits, first destinations fixed by the dest LFSR.
        load = 16'hFFFF;
        num_packets = 20;
        tready = 1'b1;
        start = 1'b1;
        acc_dest.delete();
        acc_seq.delete();
        wait_done("a_done", 500);
        check("a_total", 64'(total_sent_packets), 64'd20);
        check("a_dest0", 64'(acc_dest[0]), 64'd0);
        check("a_dest1", 64'(acc_dest[1]), 64'd0);
        check("a_dest2", 64'(acc_dest[2]), 64'd8);
        check("a_seq1", 64'(acc_seq[1]), 64'd1);
        check("a_seq2", 64'(acc_seq[2]), 64'd0);
        end_run();

        // Zero packets: done one cycle after start, no flit.
        num_packets = 0;
        start = 1'b1;
        cyc();
        check("b_done", 64'(done), 64'd1);
        check("b_tvalid", 64'(tvalid), 64'd0);
        end_run();
        check("b_done_clr", 64'(done), 64'd0);

        // Back-pressure: tready low for 50 cycles, then random.
        load = 16'h8000;
        num_packets = 60;
        tready = 1'b0;
        start = 1'b1;
        repeat (50) cyc();
        check("c_stall_valid", 64'(tvalid), 64'd1);
        check("c_stall_total", 64'(total_sent_packets), 64'd20);
        rmode = 1;
        wait_done("c_done", 2000);
        check("c_total", 64'(total_sent_packets), 64'd80);
        end_run();

        // Load 0.3, random ready, counters persist across runs.
        load = 16'h4CCD;
        num_packets = 300;
        start = 1'b1;
        wait_done("d_done", 5000);
        check("d_total", 64'(total_sent_packets), 64'd380);
        sum = 0;
        for (int i = 0; i < NR; i++) sum += int'(sent_packets[i]);
        check("d_sum", 64'(sum), 64'(total_sent_packets));
        end_run();

        // Zero load: run never finishes; reset returns everything to idle.
        load = 16'h0000;
        num_packets = 10;
        start = 1'b1;
        repeat (100) cyc();
        check("e_done", 64'(done), 64'd0);
        check("e_tvalid", 64'(tvalid), 64'd0);
        rst_n = 1'b0;
        model_reset();
        #1;
        check("e_rst_total", 64'(total_sent_packets), 64'd0);
        cyc();
        rst_n = 1'b1;
        start = 1'b0;
        cyc();

        // Reset in the middle of a stalled flit clears tvalid without a clock.
        rmode = 0;
        load = 16'hFFFF;
        num_packets = 50;
        tready = 1'b0;
        start = 1'b1;
        repeat (10) cyc();
        check("f_valid", 64'(tvalid), 64'd1);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("f_async_tvalid", 64'(tvalid), 64'd0);
        check("f_async_total", 64'(total_sent_packets), 64'd0);
        cyc();
        rst_n = 1'b1;
        rmode = 1;
        num_packets = 30;
        wait_done("f_done", 1000);
        check("f_total", 64'(total_sent_packets), 64'd30);
        end_run();

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
